// File: rtl/dir_test.sv
// Direction detector: three active-low IR sensors; IR1->IR2->IR3 runs forward, IR3->IR2->IR1 reverse.
// Optional sequence timeout is enabled by defining DIR_TEST_TIMEOUT_EN.
module dir_test #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned TMR_W       = 9
) (
    input  logic CLK,
    input  logic RST,
    input  logic IR1,
    input  logic IR2,
    input  logic IR3,
    input  logic SW,
    output logic dir,
    output logic en
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("dir_test: SYNC_STAGES must be at least 2");
    end
    if (TMR_W < $clog2(TIMEOUT_CYC + 1)) begin : g_bad_tmr
        $error("dir_test: TMR_W too narrow for TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        IDLE, FWD1, FWD2, REV1, REV2, RUN_FWD, RUN_REV
    } state_t;

    logic [2:0]             ir_sync_q [SYNC_STAGES];
    logic [2:0]             ir_sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sw_sync_q, sw_sync_d;
    logic [2:0]             ir_prev_q, ir_prev_d;
    logic [2:0]             fall_q, fall_d;
    state_t                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic                   en_q, en_d;
    logic                   sw_lvl;
    logic                   f1, f2, f3;

    assign sw_lvl = sw_sync_q[SYNC_STAGES-1];
    assign f1     = fall_q[0];
    assign f2     = fall_q[1];
    assign f3     = fall_q[2];
    assign dir    = dir_q;
    assign en     = en_q;

    // Falling edges are registered, so the FSM acts one cycle after the synchronizer output drops.
    always_comb begin
        ir_sync_d[0] = {IR3, IR2, IR1};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            ir_sync_d[i] = ir_sync_q[i-1];
        end
        sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], SW};
        ir_prev_d = ir_sync_q[SYNC_STAGES-1];
        fall_d    = ir_prev_q & ~ir_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                ir_sync_q[i] <= '1;
            end
            sw_sync_q <= '0;
            ir_prev_q <= '1;
            fall_q    <= '0;
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                ir_sync_q[i] <= ir_sync_d[i];
            end
            sw_sync_q <= sw_sync_d;
            ir_prev_q <= ir_prev_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            en_q      <= en_d;
        end
    end

`ifdef DIR_TEST_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending;

    assign pending = (state_q == FWD1) || (state_q == FWD2) ||
                     (state_q == REV1) || (state_q == REV2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`endif

    // Within each state: completing edge, then advancing edge, then restart edge.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        en_d    = en_q;
        if (sw_lvl) begin
            state_d = IDLE;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                FWD1: begin
                    if (f2)      state_d = FWD2;
                    else if (f3) state_d = REV1;
                end
                FWD2: begin
                    if (f3) begin
                        state_d = RUN_FWD;
                        dir_d   = 1'b1;
                        en_d    = 1'b1;
                    end else if (f1) begin
                        state_d = FWD1;
                    end
                end
                REV1: begin
                    if (f2)      state_d = REV2;
                    else if (f1) state_d = FWD1;
                end
                REV2: begin
                    if (f1) begin
                        state_d = RUN_REV;
                        dir_d   = 1'b0;
                        en_d    = 1'b1;
                    end else if (f3) begin
                        state_d = REV1;
                    end
                end
                IDLE, RUN_FWD, RUN_REV: begin
                    if (f1)      state_d = FWD1;
                    else if (f3) state_d = REV1;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef DIR_TEST_TIMEOUT_EN
        if (!sw_lvl && pending && (state_d == state_q) &&
            (timer_q == TMR_W'(TIMEOUT_CYC - 1))) begin
            state_d = en_q ? (dir_q ? RUN_FWD : RUN_REV) : IDLE;
        end
        if (state_d != state_q) timer_d = '0;
        else if (pending)       timer_d = timer_q + 1'b1;
        else                    timer_d = '0;
`endif
    end

endmodule

// File: tb/tb_dir_test.sv
// Self-checking bench for dir_test: directed sweeps, a vector table and randomized sensor activity
// compared against a sequence-matching reference model.
module tb_dir_test;

    localparam int S = 2;

    logic CLK;
    logic RST;
    logic IR1, IR2, IR3, SW;
    logic dir, en;

    int total = 0;
    int bad   = 0;

    dir_test #(.SYNC_STAGES(S), .TIMEOUT_CYC(256), .TMR_W(9)) dut (
        .CLK(CLK), .RST(RST), .IR1(IR1), .IR2(IR2), .IR3(IR3), .SW(SW),
        .dir(dir), .en(en)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: progress along a sequence is a direction (+1/-1) and a count
    // of sensors matched; the next expected sensor follows arithmetically.
    typedef struct {
        int   d;
        int   n;
        logic dir;
        logic en;
    } mstate_t;

    function automatic mstate_t step(mstate_t s, logic sw, logic [3:1] f);
        mstate_t r;
        int nxt;
        r = s;
        if (sw) begin
            r.d = 0; r.n = 0; r.en = 1'b0;
            return r;
        end
        if (s.n > 0) begin
            nxt = (s.d > 0 ? 1 : 3) + s.d * s.n;
            if (f[nxt]) begin
                r.n = s.n + 1;
                if (r.n == 3) begin
                    r.dir = (s.d > 0);
                    r.en  = 1'b1;
                    r.n   = 0;
                    r.d   = 0;
                end
                return r;
            end
        end
        if (f[1] && !(s.d > 0 && s.n == 1)) begin
            r.d = 1; r.n = 1;
        end else if (f[3] && !(s.d < 0 && s.n == 1)) begin
            r.d = -1; r.n = 1;
        end
        return r;
    endfunction

    logic [3:0] hist [S+2];
    logic [3:1] mf;
    mstate_t    m;

    assign mf = hist[S+1][2:0] & ~hist[S][2:0];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < S + 2; i++) hist[i] <= 4'b0111;
            m <= '{d: 0, n: 0, dir: 1'b0, en: 1'b0};
        end else begin
            hist[0] <= {SW, IR3, IR2, IR1};
            for (int i = 1; i < S + 2; i++) hist[i] <= hist[i-1];
            m <= step(m, hist[S-1][3], mf);
        end
    end

    always @(negedge CLK) begin
        check("model_dir", dir, m.dir);
        check("model_en", en, m.en);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_ir(input int s, input logic v);
        case (s)
            1: IR1 = v;
            2: IR2 = v;
            3: IR3 = v;
            default: ;
        endcase
    endtask

    task automatic pulse(input int s);
        if (s != 0) begin
            set_ir(s, 1'b0);
            tick(3);
            set_ir(s, 1'b1);
            tick(3);
        end
    endtask

    typedef struct {
        int   a, b, c;
        logic sw;
        logic exp_dir;
        logic exp_en;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{a: 1, b: 2, c: 3, sw: 1'b0, exp_dir: 1'b1, exp_en: 1'b1};
        vecs[1]  = '{a: 3, b: 2, c: 1, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};
        vecs[2]  = '{a: 1, b: 3, c: 2, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};
        vecs[3]  = '{a: 1, b: 0, c: 0, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};
        vecs[4]  = '{a: 1, b: 2, c: 3, sw: 1'b1, exp_dir: 1'b1, exp_en: 1'b0};
        vecs[5]  = '{a: 2, b: 0, c: 0, sw: 1'b0, exp_dir: 1'b1, exp_en: 1'b0};
        vecs[6]  = '{a: 3, b: 2, c: 0, sw: 1'b0, exp_dir: 1'b1, exp_en: 1'b0};
        vecs[7]  = '{a: 1, b: 0, c: 0, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};
        vecs[8]  = '{a: 1, b: 2, c: 1, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};
        vecs[9]  = '{a: 2, b: 3, c: 0, sw: 1'b0, exp_dir: 1'b1, exp_en: 1'b1};
        vecs[10] = '{a: 3, b: 3, c: 1, sw: 1'b0, exp_dir: 1'b1, exp_en: 1'b1};
        vecs[11] = '{a: 3, b: 2, c: 1, sw: 1'b0, exp_dir: 1'b0, exp_en: 1'b1};

        RST = 1'b1; IR1 = 1'b1; IR2 = 1'b1; IR3 = 1'b1; SW = 1'b0;
        tick(3);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("reset_dir", dir, 1'b0);
            check("reset_en", en, 1'b0);
        end

        // Overlapping forward sweep with exact output latency
        IR1 = 1'b0; tick(3);
        IR2 = 1'b0; tick(4);
        IR3 = 1'b0; tick(3);
        check("fwd_latency_en_early", en, 1'b0);
        tick(1);
        check("fwd_latency_en", en, 1'b1);
        check("fwd_latency_dir", dir, 1'b1);
        tick(36); IR1 = 1'b1;
        tick(3);  IR2 = 1'b1;
        tick(4);  IR3 = 1'b1;
        tick(10);
        check("fwd_hold_dir", dir, 1'b1);
        check("fwd_hold_en", en, 1'b1);

        // Overlapping reverse sweep; en must never drop
        tick(32);
        IR3 = 1'b0; tick(3);
        IR2 = 1'b0; tick(4);
        IR1 = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick(1);
            check("rev_en_steady", en, 1'b1);
        end
        IR1 = 1'b1; IR2 = 1'b1; IR3 = 1'b1;
        tick(10);
        check("rev_dir", dir, 1'b0);
        check("rev_en", en, 1'b1);

        // Stop switch while running forward
        pulse(1); pulse(2); pulse(3); tick(4);
        check("sw_pre_dir", dir, 1'b1);
        check("sw_pre_en", en, 1'b1);
        SW = 1'b1; tick(5);
        check("sw_en", en, 1'b0);
        check("sw_dir", dir, 1'b1);
        SW = 1'b0; tick(4);
        pulse(1); pulse(2); pulse(3); tick(4);
        check("sw_reenable_en", en, 1'b1);
        check("sw_reenable_dir", dir, 1'b1);

        // Asynchronous reset mid-sequence
        pulse(1); pulse(2); tick(2);
        #2 RST = 1'b1;
        #1;
        check("async_rst_dir", dir, 1'b0);
        check("async_rst_en", en, 1'b0);
        #1 RST = 1'b0;
        tick(2);

        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].a);
            pulse(vecs[i].b);
            pulse(vecs[i].c);
            if (vecs[i].sw) begin
                SW = 1'b1; tick(5); SW = 1'b0;
            end
            tick(6);
            check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) IR1 = ~IR1;
            if ($urandom_range(0, 5) == 0) IR2 = ~IR2;
            if ($urandom_range(0, 5) == 0) IR3 = ~IR3;
            SW = ($urandom_range(0, 40) == 0);
            tick(1);
        end
        IR1 = 1'b1; IR2 = 1'b1; IR3 = 1'b1; SW = 1'b0;
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
